// File: rtl/song_reader_if.sv
// Bundle of the controller, note-player and song-ROM signals seen by song_reader.
interface song_reader_if #(
  parameter int unsigned SONG_BITS = 2,
  parameter int unsigned NOTE_BITS = 5,
  parameter int unsigned NOTE_W    = 6,
  parameter int unsigned DUR_W     = 6
);
  localparam int unsigned ADDR_W = SONG_BITS + NOTE_BITS;
  localparam int unsigned ROM_W  = NOTE_W + DUR_W;

  logic              play;
  logic              reset_play;
  logic              NextSong;
  logic              note_done;
  logic [ROM_W-1:0]  rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [NOTE_W-1:0] note;
  logic [DUR_W-1:0]  duration;
  logic              new_note;
  logic              song_done;

  // Environment side: controller, note player and ROM.
  modport master (
    output play, reset_play, NextSong, note_done, rom_data,
    input  rom_addr, note, duration, new_note, song_done
  );

  // Sequencer side.
  modport slave (
    input  play, reset_play, NextSong, note_done, rom_data,
    output rom_addr, note, duration, new_note, song_done
  );
endinterface

// File: rtl/song_reader.sv
// Walks the notes of the selected song in the song ROM and hands them one at a
// time to the note player; flags song_done when the end marker or the last
// note slot has been played.
module song_reader #(
  parameter int unsigned SONG_BITS = 2,
  parameter int unsigned NOTE_BITS = 5,
  parameter int unsigned NOTE_W    = 6,
  parameter int unsigned DUR_W     = 6
) (
  input logic          clk,
  input logic          reset,
  song_reader_if.slave bus
);
  localparam int unsigned ROM_W = NOTE_W + DUR_W;
  localparam logic [NOTE_BITS-1:0] LAST_IDX = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DATA  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                 state, state_nxt;
  logic [SONG_BITS-1:0]   song, song_nxt;
  logic [NOTE_BITS-1:0]   note_idx, note_idx_nxt;
  logic [NOTE_W-1:0]      note_q, note_nxt;
  logic [DUR_W-1:0]       duration_q, duration_nxt;
  logic                   new_note_q, new_note_nxt;
  logic                   song_done_q, song_done_nxt;

  logic                   note_accept;
  logic                   last_slot;
  logic                   rom_end;

  // A note_done in the same cycle as the new_note pulse is deliberately dropped.
  assign note_accept = (state == HOLD) && bus.note_done && !new_note_q;
  assign last_slot   = (note_idx == LAST_IDX);
  assign rom_end     = (bus.rom_data == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; NextSong/reset_play rewind ahead of normal sequencing.
  always_comb begin
    state_nxt = state;
    if (bus.NextSong || bus.reset_play) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.play) state_nxt = FETCH;
        FETCH:   if (bus.play) state_nxt = DATA;
        DATA:    if (bus.play) state_nxt = rom_end ? DONE : HOLD;
        HOLD:    if (note_accept) state_nxt = last_slot ? DONE : FETCH;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Next values of the song/note pointers and the registered outputs.
  always_comb begin
    song_nxt      = song;
    note_idx_nxt  = note_idx;
    note_nxt      = note_q;
    duration_nxt  = duration_q;
    new_note_nxt  = 1'b0;
    song_done_nxt = (state_nxt == DONE);
    if (bus.NextSong) begin
      song_nxt     = song + SONG_BITS'(1);
      note_idx_nxt = '0;
    end else if (bus.reset_play) begin
      note_idx_nxt = '0;
    end else begin
      case (state)
        DATA: begin
          if (bus.play && !rom_end) begin
            note_nxt     = bus.rom_data[ROM_W-1:DUR_W];
            duration_nxt = bus.rom_data[DUR_W-1:0];
            new_note_nxt = 1'b1;
          end
        end
        HOLD: begin
          if (note_accept && !last_slot) note_idx_nxt = note_idx + NOTE_BITS'(1);
        end
        default: ;
      endcase
    end
  end

  // Pointer and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      song        <= '0;
      note_idx    <= '0;
      note_q      <= '0;
      duration_q  <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      song        <= song_nxt;
      note_idx    <= note_idx_nxt;
      note_q      <= note_nxt;
      duration_q  <= duration_nxt;
      new_note_q  <= new_note_nxt;
      song_done_q <= song_done_nxt;
    end
  end

  assign bus.rom_addr  = {song, note_idx};
  assign bus.note      = note_q;
  assign bus.duration  = duration_q;
  assign bus.new_note  = new_note_q;
  assign bus.song_done = song_done_q;
endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader with a registered song-ROM model.
module tb_song_reader;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   nn_count;

  logic [11:0] rom [128];

  song_reader_if #(.SONG_BITS(2), .NOTE_BITS(5), .NOTE_W(6), .DUR_W(6)) bus ();

  song_reader #(.SONG_BITS(2), .NOTE_BITS(5), .NOTE_W(6), .DUR_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Song ROM: data valid one cycle after the address.
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  // Count new_note pulses, sampled away from the active edge.
  always @(negedge clk) if (bus.new_note === 1'b1) nn_count++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (bus.rom_addr !== 7'd0) begin failures++; $display("FAIL reset_rom_addr got=%0d want=0", bus.rom_addr); end
    checks++; if (bus.note !== 6'd0) begin failures++; $display("FAIL reset_note got=%0d want=0", bus.note); end
    checks++; if (bus.duration !== 6'd0) begin failures++; $display("FAIL reset_duration got=%0d want=0", bus.duration); end
    checks++; if (bus.new_note !== 1'b0) begin failures++; $display("FAIL reset_new_note got=%b want=0", bus.new_note); end
    checks++; if (bus.song_done !== 1'b0) begin failures++; $display("FAIL reset_song_done got=%b want=0", bus.song_done); end
  endtask

  task automatic test_basic();
    int n0;
    bus.play = 1'b1;
    tick();
    tick();
    checks++; if (bus.new_note !== 1'b0) begin failures++; $display("FAIL basic_early_pulse got=%b want=0", bus.new_note); end
    tick();
    checks++; if (bus.new_note !== 1'b1) begin failures++; $display("FAIL basic_first_pulse got=%b want=1", bus.new_note); end
    checks++; if (bus.note !== 6'd10 || bus.duration !== 6'd4) begin failures++; $display("FAIL basic_first_note got=%0d/%0d want=10/4", bus.note, bus.duration); end
    tick();
    checks++; if (bus.new_note !== 1'b0) begin failures++; $display("FAIL basic_pulse_width got=%b want=0", bus.new_note); end
    bus.note_done = 1'b1;
    tick();
    bus.note_done = 1'b0;
    checks++; if (bus.rom_addr !== 7'd1) begin failures++; $display("FAIL basic_addr_step got=%0d want=1", bus.rom_addr); end
    tick();
    checks++; if (bus.new_note !== 1'b0) begin failures++; $display("FAIL basic_second_early got=%b want=0", bus.new_note); end
    tick();
    checks++; if (bus.new_note !== 1'b1 || bus.note !== 6'd12) begin failures++; $display("FAIL basic_second_note got=%b/%0d want=1/12", bus.new_note, bus.note); end
    tick();
    bus.note_done = 1'b1;
    tick();
    bus.note_done = 1'b0;
    tick();
    tick();
    checks++; if (bus.song_done !== 1'b1) begin failures++; $display("FAIL basic_song_done got=%b want=1", bus.song_done); end
    n0 = nn_count;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (bus.song_done !== 1'b1) begin failures++; $display("FAIL basic_done_hold got=%b want=1", bus.song_done); end
    checks++; if (nn_count !== n0) begin failures++; $display("FAIL basic_done_quiet got=%0d want=%0d", nn_count, n0); end
  endtask

  task automatic test_full_song();
    int  n0;
    logic got;
    for (int k = 0; k < 32; k++) rom[k] = {6'(k + 1), 6'd2};
    bus.play = 1'b0;
    bus.reset_play = 1'b1;
    tick();
    bus.reset_play = 1'b0;
    checks++; if (bus.song_done !== 1'b0) begin failures++; $display("FAIL full_rewind_done got=%b want=0", bus.song_done); end
    n0 = nn_count;
    bus.play = 1'b1;
    for (int k = 0; k < 32; k++) begin
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
        tick();
        got = bus.new_note;
      end
      checks++;
      if (!got || bus.note !== 6'(k + 1) || bus.duration !== 6'd2) begin
        failures++;
        $display("FAIL full_note%0d got=%b/%0d/%0d want=1/%0d/2", k, got, bus.note, bus.duration, k + 1);
      end
      tick();
      bus.note_done = 1'b1;
      tick();
      bus.note_done = 1'b0;
    end
    checks++; if (bus.song_done !== 1'b1) begin failures++; $display("FAIL full_song_done got=%b want=1", bus.song_done); end
    checks++; if (bus.rom_addr !== 7'd31) begin failures++; $display("FAIL full_final_addr got=%0d want=31", bus.rom_addr); end
    for (int i = 0; i < 6; i++) tick();
    checks++; if (nn_count - n0 !== 32) begin failures++; $display("FAIL full_note_count got=%0d want=32", nn_count - n0); end
  endtask

  task automatic test_next_song();
    logic [1:0] exp_song;
    logic [6:0] exp_addr;
    bus.play = 1'b0;
    exp_song = 2'd0;
    for (int p = 0; p < 4; p++) begin
      exp_song = exp_song + 2'd1;
      exp_addr = {exp_song, 5'd0};
      bus.NextSong = 1'b1;
      tick();
      bus.NextSong = 1'b0;
      checks++;
      if (bus.rom_addr !== exp_addr || bus.song_done !== 1'b0) begin
        failures++;
        $display("FAIL next_song%0d got=%0d/%b want=%0d/0", p, bus.rom_addr, bus.song_done, exp_addr);
      end
      tick();
    end
  endtask

  task automatic test_pause();
    int n0;
    n0 = nn_count;
    bus.play = 1'b1;
    tick();
    bus.play = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (nn_count !== n0) begin failures++; $display("FAIL pause_fetch_hold got=%0d want=%0d", nn_count - n0, 0); end
    bus.play = 1'b1;
    tick();
    checks++; if (bus.new_note !== 1'b0) begin failures++; $display("FAIL pause_early got=%b want=0", bus.new_note); end
    tick();
    checks++; if (bus.new_note !== 1'b1 || bus.note !== 6'd1) begin failures++; $display("FAIL pause_resume got=%b/%0d want=1/1", bus.new_note, bus.note); end
  endtask

  task automatic test_reset_play_hold();
    int  n0;
    logic got;
    for (int k = 0; k < 5; k++) begin
      tick();
      bus.note_done = 1'b1;
      tick();
      bus.note_done = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
        tick();
        got = bus.new_note;
      end
    end
    checks++; if (bus.rom_addr !== 7'd5 || bus.note !== 6'd6) begin failures++; $display("FAIL rp_at_idx5 got=%0d/%0d want=5/6", bus.rom_addr, bus.note); end
    tick();
    bus.play = 1'b0;
    bus.reset_play = 1'b1;
    tick();
    bus.reset_play = 1'b0;
    checks++; if (bus.rom_addr !== 7'd0) begin failures++; $display("FAIL rp_rewind got=%0d want=0", bus.rom_addr); end
    n0 = nn_count;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (nn_count !== n0) begin failures++; $display("FAIL rp_quiet got=%0d want=0", nn_count - n0); end
    bus.play = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (bus.new_note !== 1'b1 || bus.note !== 6'd1 || bus.rom_addr !== 7'd0) begin failures++; $display("FAIL rp_restart got=%b/%0d/%0d want=1/1/0", bus.new_note, bus.note, bus.rom_addr); end
  endtask

  task automatic test_simultaneous();
    int  n0;
    logic got;
    bus.play = 1'b0;
    bus.NextSong = 1'b1;
    bus.reset_play = 1'b1;
    tick();
    bus.NextSong = 1'b0;
    bus.reset_play = 1'b0;
    checks++; if (bus.rom_addr !== 7'd32) begin failures++; $display("FAIL sim_next_and_rewind got=%0d want=32", bus.rom_addr); end
    reset = 1'b1;
    bus.NextSong = 1'b1;
    tick();
    reset = 1'b0;
    bus.NextSong = 1'b0;
    checks++; if (bus.rom_addr !== 7'd0 || bus.note !== 6'd0 || bus.duration !== 6'd0) begin failures++; $display("FAIL sim_reset_wins got=%0d/%0d/%0d want=0/0/0", bus.rom_addr, bus.note, bus.duration); end
    bus.play = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      got = bus.new_note;
    end
    bus.note_done = 1'b1;
    tick();
    bus.note_done = 1'b0;
    n0 = nn_count;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (nn_count !== n0 || bus.rom_addr !== 7'd0) begin failures++; $display("FAIL sim_coincident_ignored got=%0d/%0d want=0/0", nn_count - n0, bus.rom_addr); end
    bus.note_done = 1'b1;
    tick();
    bus.note_done = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      got = bus.new_note;
    end
    checks++; if (!got || bus.note !== 6'd2) begin failures++; $display("FAIL sim_no_skip got=%b/%0d want=1/2", got, bus.note); end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    nn_count   = 0;
    reset      = 1'b1;
    bus.play       = 1'b0;
    bus.reset_play = 1'b0;
    bus.NextSong   = 1'b0;
    bus.note_done  = 1'b0;
    for (int a = 0; a < 128; a++) rom[a] = 12'd0;
    rom[0] = {6'd10, 6'd4};
    rom[1] = {6'd12, 6'd4};
    rom[2] = 12'd0;
    test_reset();
    test_basic();
    test_full_song();
    test_next_song();
    test_pause();
    test_reset_play_hold();
    test_simultaneous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
